// File: rtl/led_display_arbiter.sv
// Front-panel LED owner arbiter: JTAG > startup > status, with a minimum
// dwell per non-JTAG owner and a blanked gap between owners.
//
// Ports:
//   CLK, RST           clock, async active-high reset
//   TICK               timebase strobe for dwell/gap counters
//   JTAG_REQ/PAT       override request and pattern (never preempted)
//   STUP_REQ/PAT       startup sequencer request and pattern
//   STAT_REQ/PAT       status monitor request and pattern
//   JTAG/STUP/STAT_GNT one-hot ownership grants (registered)
//   LEDS               registered LED drive
//   BLANK              high when nobody owns the display
module led_display_arbiter #(
  parameter logic [15:0] MIN_DWELL = 16'd3000,
  parameter logic [3:0]  GAP_TICKS = 4'd2,
  parameter logic [7:0]  IDLE_PAT  = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       JTAG_REQ,
  input  logic [7:0] JTAG_PAT,
  input  logic       STUP_REQ,
  input  logic [7:0] STUP_PAT,
  input  logic       STAT_REQ,
  input  logic [7:0] STAT_PAT,
  output logic       JTAG_GNT,
  output logic       STUP_GNT,
  output logic       STAT_GNT,
  output logic [7:0] LEDS,
  output logic       BLANK
);

  typedef enum logic [2:0] {
    IDLE,
    OWN_JTAG,
    OWN_STUP,
    OWN_STAT,
    GAP
  } state_t;

  state_t state;
  state_t state_nx;

  // Requests are sampled into flops; the FSM acts on the sampled copy,
  // giving the one-clock sample + one-clock grant latency.
  logic jtag_q;
  logic stup_q;
  logic stat_q;

  logic [15:0] dwell;
  logic [3:0]  gap;
  logic        dwell_done;
  logic        gap_done;
  logic        own_cur;
  logic        own_nx;

  logic       jtag_gnt_nx;
  logic       stup_gnt_nx;
  logic       stat_gnt_nx;
  logic [7:0] leds_nx;

  function automatic logic is_own(input state_t s);
    return (s == OWN_JTAG) || (s == OWN_STUP) || (s == OWN_STAT);
  endfunction

  assign dwell_done = (dwell == MIN_DWELL);
  assign gap_done   = (gap == GAP_TICKS);
  assign own_cur    = is_own(state);
  assign own_nx     = is_own(state_nx);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      jtag_q <= 1'b0;
      stup_q <= 1'b0;
      stat_q <= 1'b0;
    end else begin
      jtag_q <= JTAG_REQ;
      stup_q <= STUP_REQ;
      stat_q <= STAT_REQ;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (jtag_q) begin
          state_nx = OWN_JTAG;
        end else if (stup_q) begin
          state_nx = OWN_STUP;
        end else if (stat_q) begin
          state_nx = OWN_STAT;
        end
      end
      OWN_JTAG: begin
        if (!jtag_q) begin
          state_nx = GAP;
        end
      end
      OWN_STUP: begin
        if (!stup_q || jtag_q) begin
          state_nx = GAP;
        end
      end
      OWN_STAT: begin
        // JTAG preempts at once; startup must wait out the dwell.
        if (!stat_q || jtag_q || (stup_q && dwell_done)) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Dwell counter: cleared on entry to any owned state, saturates.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell <= 16'd0;
    end else if (own_nx && (state_nx != state)) begin
      dwell <= 16'd0;
    end else if (own_cur && TICK && !dwell_done) begin
      dwell <= dwell + 16'd1;
    end
  end

  // Gap counter: cleared on entry to Gap, stops at its compare value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gap <= 4'd0;
    end else if ((state_nx == GAP) && (state != GAP)) begin
      gap <= 4'd0;
    end else if ((state == GAP) && TICK && !gap_done) begin
      gap <= gap + 4'd1;
    end
  end

  always_comb begin
    jtag_gnt_nx = 1'b0;
    stup_gnt_nx = 1'b0;
    stat_gnt_nx = 1'b0;
    leds_nx     = IDLE_PAT;
    case (state_nx)
      OWN_JTAG: begin
        jtag_gnt_nx = 1'b1;
        leds_nx     = JTAG_PAT;
      end
      OWN_STUP: begin
        stup_gnt_nx = 1'b1;
        leds_nx     = STUP_PAT;
      end
      OWN_STAT: begin
        stat_gnt_nx = 1'b1;
        leds_nx     = STAT_PAT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      JTAG_GNT <= 1'b0;
      STUP_GNT <= 1'b0;
      STAT_GNT <= 1'b0;
      LEDS     <= IDLE_PAT;
      BLANK    <= 1'b1;
    end else begin
      JTAG_GNT <= jtag_gnt_nx;
      STUP_GNT <= stup_gnt_nx;
      STAT_GNT <= stat_gnt_nx;
      LEDS     <= leds_nx;
      BLANK    <= !own_nx;
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Scoreboard bench for led_display_arbiter (MIN_DWELL=4, GAP_TICKS=2,
// TICK every cycle). Observation word = {JTAG,STUP,STAT GNT, BLANK, LEDS}.
module tb_led_display_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       TICK = 1'b1;
  logic       JTAG_REQ = 1'b0;
  logic [7:0] JTAG_PAT = 8'h00;
  logic       STUP_REQ = 1'b0;
  logic [7:0] STUP_PAT = 8'h00;
  logic       STAT_REQ = 1'b0;
  logic [7:0] STAT_PAT = 8'h00;
  logic       JTAG_GNT;
  logic       STUP_GNT;
  logic       STAT_GNT;
  logic [7:0] LEDS;
  logic       BLANK;

  int checks = 0;
  int failures = 0;

  logic [11:0] sb[$];

  localparam logic [11:0] BLK = {3'b000, 1'b1, 8'h00};

  led_display_arbiter #(
    .MIN_DWELL(16'd4),
    .GAP_TICKS(4'd2),
    .IDLE_PAT (8'h00)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TICK    (TICK),
    .JTAG_REQ(JTAG_REQ),
    .JTAG_PAT(JTAG_PAT),
    .STUP_REQ(STUP_REQ),
    .STUP_PAT(STUP_PAT),
    .STAT_REQ(STAT_REQ),
    .STAT_PAT(STAT_PAT),
    .JTAG_GNT(JTAG_GNT),
    .STUP_GNT(STUP_GNT),
    .STAT_GNT(STAT_GNT),
    .LEDS    (LEDS),
    .BLANK   (BLANK)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] own(input logic [2:0] g,
                                      input logic [7:0] p);
    return {g, 1'b0, p};
  endfunction

  function automatic logic [11:0] get_obs();
    return {JTAG_GNT, STUP_GNT, STAT_GNT, BLANK, LEDS};
  endfunction

  task automatic push(input int n, input logic [11:0] v);
    repeat (n) sb.push_back(v);
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    #1 RST = 1'b1;
    #1;
    checks++;
    if (get_obs() !== BLK) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", get_obs(), BLK);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    sb = {};
    push(4, BLK);
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL reset_idle c%0d got=%h exp=%h", i, get_obs(), exp);
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(1, own(3'b001, 8'h5A));
    push(2, own(3'b001, 8'hA5));
    push(5, BLK);
    STAT_PAT = 8'h5A;
    STAT_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL single c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      case (i)
        2: STAT_PAT = 8'hA5;
        3: STAT_REQ = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(3, own(3'b010, 8'h11));
    push(4, BLK);
    STUP_PAT = 8'h11;
    STAT_PAT = 8'h22;
    STUP_REQ = 1'b1;
    STAT_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL simul c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      if (i == 3) begin
        STUP_REQ = 1'b0;
        STAT_REQ = 1'b0;
      end
    end
  endtask

  task automatic test_dwell();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(5, own(3'b001, 8'h33));
    push(4, BLK);
    push(2, own(3'b010, 8'h44));
    push(4, BLK);
    STAT_PAT = 8'h33;
    STAT_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL dwell c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      case (i)
        3: begin
          STUP_PAT = 8'h44;
          STUP_REQ = 1'b1;
        end
        11: begin
          STUP_REQ = 1'b0;
          STAT_REQ = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_jtag();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(3, own(3'b010, 8'h66));
    push(4, BLK);
    push(5, own(3'b100, 8'hFF));
    push(4, BLK);
    push(2, own(3'b010, 8'h66));
    push(4, BLK);
    STUP_PAT = 8'h66;
    STUP_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL jtag c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      case (i)
        3: begin
          JTAG_PAT = 8'hFF;
          JTAG_REQ = 1'b1;
        end
        12: JTAG_REQ = 1'b0;
        18: STUP_REQ = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(2, own(3'b001, 8'h77));
    push(4, BLK);
    push(2, own(3'b001, 8'h77));
    push(4, BLK);
    STAT_PAT = 8'h77;
    STAT_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL b2b c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      case (i)
        2: STAT_REQ = 1'b0;
        4: STAT_REQ = 1'b1;
        8: STAT_REQ = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    sb = {};
    push(1, BLK);
    push(2, own(3'b100, 8'hC3));
    push(2, BLK);
    push(3, own(3'b100, 8'hC3));
    push(4, BLK);
    JTAG_PAT = 8'hC3;
    JTAG_REQ = 1'b1;
    for (int i = 1; sb.size() > 0; i++) begin
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      checks++;
      if (get_obs() !== exp) begin
        failures++;
        $display("FAIL rst_mid c%0d got=%h exp=%h", i, get_obs(), exp);
      end
      case (i)
        3: begin
          #2 RST = 1'b1;
          #1;
          checks++;
          if (get_obs() !== BLK) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=%h", get_obs(), BLK);
          end
        end
        4: RST = 1'b0;
        7: JTAG_REQ = 1'b0;
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_dwell();
    test_jtag();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
